context_scheduler: RTL and testbench

CONTEXT_SCHEDULER -- requirements
Module: context_scheduler

---
 rtl/context_scheduler.sv | 116 +++++++++++
 tb/tb_context_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/context_scheduler.sv
// Round-robin issue scheduler over N hardware contexts with per-context wait counters.
// A blocked context is held off until its counter drains; stall freezes the issue stage only.
`ifndef LEN_CONTEXT_ID
`define LEN_CONTEXT_ID 2
`endif

module context_scheduler #(
    parameter int LEN_CONTEXT_ID = `LEN_CONTEXT_ID,
    parameter int LEN_WAIT       = 4,
    localparam int N             = 2**LEN_CONTEXT_ID
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              ctx_ready,
    input  logic                      stall,
    input  logic                      block_valid,
    input  logic [LEN_CONTEXT_ID-1:0] block_id,
    input  logic [LEN_WAIT-1:0]       block_cycles,
    output logic                      issue_valid,
    output logic [N-1:0]              issue_ctx,
    output logic [LEN_CONTEXT_ID-1:0] issue_id,
    output logic [N-1:0]              ctx_waiting
);

    logic                      issue_valid_q, issue_valid_d;
    logic [N-1:0]              issue_ctx_q, issue_ctx_d;
    logic [LEN_CONTEXT_ID-1:0] issue_id_q, issue_id_d;
    logic [N-1:0]              ptr_q, ptr_d;
    logic [LEN_WAIT-1:0]       cnt_q [N];
    logic [LEN_WAIT-1:0]       cnt_d [N];

    logic [LEN_CONTEXT_ID-1:0] ptr_idx;
    logic [LEN_CONTEXT_ID-1:0] scan_idx;
    logic [LEN_CONTEXT_ID-1:0] grant_id;
    logic [N-1:0]              eligible;
    logic [N-1:0]              grant;
    logic                      found;

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++)
            if (ptr_q[i]) ptr_idx = LEN_CONTEXT_ID'(i);
    end

    // A same-cycle nonzero block masks the context even though its counter is still 0.
    always_comb begin
        for (int i = 0; i < N; i++)
            eligible[i] = ctx_ready[i] && (cnt_q[i] == '0) &&
                          !(block_valid && (block_id == LEN_CONTEXT_ID'(i)) && (block_cycles != '0));
    end

    // Scan offsets from the pointer; index arithmetic wraps naturally since N is a power of two.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = ptr_idx + LEN_CONTEXT_ID'(k);
            if (!found && eligible[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_id        = scan_idx;
                found           = 1'b1;
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_ctx_d   = issue_ctx_q;
        issue_id_d    = issue_id_q;
        ptr_d         = ptr_q;
        if (!stall) begin
            issue_valid_d = found;
            issue_ctx_d   = grant;
            issue_id_d    = grant_id;
            if (found) ptr_d = {grant[N-2:0], grant[N-1]};
        end
    end

    // Counters keep draining through stalls; a block request overrides the decrement.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (block_valid && (block_id == LEN_CONTEXT_ID'(i)))
                cnt_d[i] = block_cycles;
            else if (cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - LEN_WAIT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_ctx_q   <= '0;
            issue_id_q    <= '0;
            ptr_q         <= N'(1);
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_ctx_q   <= issue_ctx_d;
            issue_id_q    <= issue_id_d;
            ptr_q         <= ptr_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) ctx_waiting[i] = (cnt_q[i] != '0);
    end

    assign issue_valid = issue_valid_q;
    assign issue_ctx   = issue_ctx_q;
    assign issue_id    = issue_id_q;

endmodule

// File: tb/tb_context_scheduler.sv
// Scoreboard bench for context_scheduler (N=4, LEN_WAIT=4): directed scenarios plus random traffic
// against an index-based round-robin reference model.
module tb_context_scheduler;

    localparam int L  = 2;
    localparam int N  = 4;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  ctx_ready = '0;
    logic          stall = 1'b0;
    logic          block_valid = 1'b0;
    logic [L-1:0]  block_id = '0;
    logic [LW-1:0] block_cycles = '0;
    logic          issue_valid;
    logic [N-1:0]  issue_ctx;
    logic [L-1:0]  issue_id;
    logic [N-1:0]  ctx_waiting;

    context_scheduler #(.LEN_CONTEXT_ID(L), .LEN_WAIT(LW)) dut (
        .clk(clk), .rst(rst), .ctx_ready(ctx_ready), .stall(stall),
        .block_valid(block_valid), .block_id(block_id), .block_cycles(block_cycles),
        .issue_valid(issue_valid), .issue_ctx(issue_ctx), .issue_id(issue_id),
        .ctx_waiting(ctx_waiting)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [N-1:0] ctx;
        logic [L-1:0] id;
        logic [N-1:0] wt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: pointer as a plain index, counters as integers.
    int   m_ptr = 0;
    int   m_cnt [N];
    exp_t m_out = '0;

    task automatic step(input logic [N-1:0] rdy, input logic stl, input logic bv,
                        input int bid, input int bc, input logic r);
        int   g;
        exp_t e;
        @(negedge clk);
        rst          = r;
        ctx_ready    = rdy;
        stall        = stl;
        block_valid  = bv;
        block_id     = L'(bid);
        block_cycles = LW'(bc);
        if (r) begin
            m_ptr = 0;
            m_out = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && rdy[i] && m_cnt[i] == 0 && !(bv && bid == i && bc != 0)) g = i;
            end
            if (!stl) begin
                m_out.v   = (g >= 0);
                m_out.ctx = (g >= 0) ? N'(1 << g) : '0;
                m_out.id  = (g >= 0) ? L'(g) : '0;
                if (g >= 0) m_ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (bv && bid == i) m_cnt[i] = bc;
                else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
        end
        e    = m_out;
        e.wt = '0;
        for (int i = 0; i < N; i++) e.wt[i] = (m_cnt[i] != 0);
        q.push_back(e);
    endtask

    task automatic run(input logic [N-1:0] rdy, input int n);
        for (int c = 0; c < n; c++) step(rdy, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Monitor: every registered update is compared against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (issue_valid !== e.v) begin
                errors++;
                $display("FAIL issue_valid t=%0t got %b exp %b", $time, issue_valid, e.v);
            end
            checks++;
            if (issue_ctx !== e.ctx) begin
                errors++;
                $display("FAIL issue_ctx t=%0t got %b exp %b", $time, issue_ctx, e.ctx);
            end
            checks++;
            if (issue_id !== e.id) begin
                errors++;
                $display("FAIL issue_id t=%0t got %0d exp %0d", $time, issue_id, e.id);
            end
            checks++;
            if (ctx_waiting !== e.wt) begin
                errors++;
                $display("FAIL ctx_waiting t=%0t got %b exp %b", $time, ctx_waiting, e.wt);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Reset then full rotation
        step(4'b1111, 1'b0, 1'b0, 0, 0, 1'b1);
        step(4'b1111, 1'b0, 1'b0, 0, 0, 1'b1);
        run(4'b1111, 6);
        // Alternation between two ready contexts
        run(4'b0101, 5);
        // Block context 1 for 3 cycles while it is the only ready one
        step(4'b0010, 1'b0, 1'b1, 1, 3, 1'b0);
        run(4'b0010, 6);
        // Stall holds the grant of context 1 for two cycles
        step(4'b1111, 1'b0, 1'b0, 0, 0, 1'b1);
        run(4'b1111, 2);
        step(4'b1111, 1'b1, 1'b0, 0, 0, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 0, 0, 1'b0);
        run(4'b1111, 3);
        // Reset mid-wait with pointer away from context 0
        step(4'b1011, 1'b0, 1'b1, 2, 5, 1'b0);
        run(4'b1011, 2);
        step(4'b0100, 1'b0, 1'b0, 0, 0, 1'b1);
        run(4'b0100, 3);
        // Same-cycle block of the only ready context, then zero-length block
        step(4'b0001, 1'b0, 1'b1, 0, 2, 1'b0);
        run(4'b0001, 3);
        step(4'b0001, 1'b0, 1'b1, 0, 0, 1'b0);
        run(4'b0001, 2);
        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rdy;
            logic stl, bv, r;
            rdy = N'($urandom);
            stl = ($urandom_range(0, 3) == 0);
            bv  = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 99) == 0);
            step(rdy, stl, bv, $urandom_range(0, N - 1), $urandom_range(0, (1 << LW) - 1), r);
        end
        run(4'b0000, 2);

        // Let the monitor drain, bounded
        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
